// File: rtl/j1_uart_io.sv
// J1 I/O-bus UART responder: data register at BASE_ADDR, status at BASE_ADDR+2.
// 8N1 transmitter fed by a small FIFO; receiver with a single holding register.
module j1_uart_io #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          CLK_DIV   = 434,
  parameter int          TX_AW     = 3
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic [2:0]  o_rx_state
);

  localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   DIV_FULL  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   DIV_HALF  = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam int              DEPTH     = 1 << TX_AW;
  localparam logic [TX_AW:0]  PTR_ONE   = (TX_AW + 1)'(1);
  localparam logic [15:0]     STAT_ADDR = BASE_ADDR + 16'd2;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // Bus decode
  logic w_hit_d, w_hit_s, w_push_req, w_pop, w_clr;
  assign w_hit_d    = (io_addr == BASE_ADDR);
  assign w_hit_s    = (io_addr == STAT_ADDR);
  assign w_push_req = io_wr & w_hit_d;
  assign w_pop      = io_rd & w_hit_d;
  assign w_clr      = io_wr & w_hit_s;

  logic w_unused;
  assign w_unused = ^io_dout[15:8];

  // TX FIFO
  logic [7:0]     r_fifo [DEPTH];
  logic [TX_AW:0] r_wr_ptr, r_rd_ptr;
  logic           w_empty, w_full, w_tx_load, w_push, w_ovf_set;
  logic [7:0]     w_fifo_head;

  logic           r_tx_busy;
  logic [9:0]     r_tx_shift;
  logic [CW-1:0]  r_tx_cnt;
  logic [3:0]     r_tx_bit;
  logic           w_tx_done, w_tx_idle;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[TX_AW] != r_rd_ptr[TX_AW]) &&
                       (r_wr_ptr[TX_AW-1:0] == r_rd_ptr[TX_AW-1:0]);
  assign w_fifo_head = r_fifo[r_rd_ptr[TX_AW-1:0]];
  assign w_tx_done   = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bit == 4'd9);
  // Reloading on the stop-bit edge keeps back-to-back frames gapless.
  assign w_tx_load   = (~r_tx_busy | w_tx_done) & ~w_empty;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push      = w_push_req & (~w_full | w_tx_load);
  assign w_ovf_set   = w_push_req & ~w_push;
  assign w_tx_idle   = w_empty & ~r_tx_busy;

  always_ff @(posedge sys_clk_i) begin
    if (w_push) r_fifo[r_wr_ptr[TX_AW-1:0]] <= io_dout[7:0];
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_tx_load) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // TX shifter: bit 0 of the shift register is the line; all-ones is idle.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (w_tx_load) begin
      r_tx_busy  <= 1'b1;
      r_tx_shift <= {1'b1, w_fifo_head, 1'b0};
      r_tx_cnt   <= DIV_FULL;
      r_tx_bit   <= '0;
    end else if (w_tx_done) begin
      r_tx_busy  <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == '0) begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bit   <= r_tx_bit + 4'd1;
        r_tx_cnt   <= DIV_FULL;
      end else begin
        r_tx_cnt   <= r_tx_cnt - CNT_ONE;
      end
    end
  end

  assign uart_tx_o = r_tx_shift[0];

  // RX synchroniser and FSM
  logic          r_rx_meta, r_rx_sync;
  rx_state_t     r_rx_state, w_rx_next;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bits;
  logic [7:0]    r_rx_shift;
  logic          w_cnt_zero, w_cnt_half, w_cnt_full, w_sample, w_deliver, w_ferr_set;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_cnt_zero = (r_rx_cnt == '0);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) r_rx_state <= RX_IDLE;
    else              r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next  = r_rx_state;
    w_cnt_half = 1'b0;
    w_cnt_full = 1'b0;
    w_sample   = 1'b0;
    w_deliver  = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_next  = RX_START;
          w_cnt_half = 1'b1;
        end
      end
      RX_START: begin
        if (w_cnt_zero) begin
          if (!r_rx_sync) begin
            w_rx_next  = RX_DATA;
            w_cnt_full = 1'b1;
          end else begin
            w_rx_next  = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_cnt_zero) begin
          w_sample   = 1'b1;
          w_cnt_full = 1'b1;
          if (r_rx_bits == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_cnt_zero) begin
          if (r_rx_sync) begin
            w_deliver = 1'b1;
            w_rx_next = RX_IDLE;
          end else begin
            w_ferr_set = 1'b1;
            w_rx_next  = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (r_rx_sync) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  assign o_rx_state = r_rx_state;

  // Bit counter wraps 7->0 on the eighth sample, so it is ready for the next frame.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
    end else begin
      if (w_cnt_half)      r_rx_cnt <= DIV_HALF;
      else if (w_cnt_full) r_rx_cnt <= DIV_FULL;
      else if (!w_cnt_zero) r_rx_cnt <= r_rx_cnt - CNT_ONE;
      if (w_sample) begin
        r_rx_bits  <= r_rx_bits + 3'd1;
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
      end
    end
  end

  // RX holding register and sticky flags
  logic       r_rx_valid, r_rx_ovr, r_rx_ferr, r_tx_ovf;
  logic [7:0] r_rx_data;
  logic       w_ovr_set;

  assign w_ovr_set = w_deliver & r_rx_valid & ~w_pop;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else if (w_deliver & (~r_rx_valid | w_pop)) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= r_rx_shift;
    end else if (w_pop) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Write-one-to-clear; a set on the same edge wins.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else begin
      r_rx_ovr  <= (r_rx_ovr  & ~(w_clr & io_dout[3])) | w_ovr_set;
      r_rx_ferr <= (r_rx_ferr & ~(w_clr & io_dout[4])) | w_ferr_set;
      r_tx_ovf  <= (r_tx_ovf  & ~(w_clr & io_dout[5])) | w_ovf_set;
    end
  end

  logic [15:0] w_status;
  assign w_status = {10'd0, r_tx_ovf, r_rx_ferr, r_rx_ovr, r_rx_valid, w_tx_idle, w_full};

  always_comb begin
    io_din = 16'h0000;
    if (w_hit_d)      io_din = {8'h00, r_rx_data};
    else if (w_hit_s) io_din = w_status;
  end

endmodule
